// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame controller: shifts qualified bits into WIDTH-bit words and hands them out via valid/ready.
// Optional even-parity trailer bit when the PARITY_CHECK_EN macro is defined.
module sipo_frame_ctrl #(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             frame_abort,
  input  logic             out_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef PARITY_CHECK_EN
  localparam logic [1:0] PAR   = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             ovalid_q, ovalid_d;
  logic             overrun_q, overrun_d;
  logic             perr_q, perr_d;

  logic             complete;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;

  assign shifted  = {shreg_q[WIDTH-2:0], serial_in};
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Frame sequencing: abort wins over any presented bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    complete = 1'b0;
    word     = shifted;
    perr_d   = 1'b0;
    if (frame_abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      shreg_d = '0;
    end else if (serial_valid) begin
      case (state_q)
        IDLE: begin
          shreg_d = shifted;
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
        SHIFT: begin
          shreg_d = shifted;
          if (last_bit) begin
            cnt_d = '0;
`ifdef PARITY_CHECK_EN
            state_d = PAR;
`else
            state_d  = IDLE;
            complete = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef PARITY_CHECK_EN
        PAR: begin
          // Word stays held in shreg; the trailer bit must make total parity even.
          state_d = IDLE;
          word    = shreg_q;
          if ((^shreg_q) ^ serial_in) begin
            perr_d = 1'b1;
          end else begin
            complete = 1'b1;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output register: a completed word is taken unless an unconsumed word is stuck.
  always_comb begin
    pout_d    = pout_q;
    ovalid_d  = ovalid_q;
    overrun_d = overrun_clr ? 1'b0 : overrun_q;
    if (complete) begin
      if (!ovalid_q || out_ready) begin
        pout_d   = word;
        ovalid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (ovalid_q && out_ready) begin
      ovalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      pout_q    <= '0;
      ovalid_q  <= 1'b0;
      overrun_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      pout_q    <= pout_d;
      ovalid_q  <= ovalid_d;
      overrun_q <= overrun_d;
      perr_q    <= perr_d;
    end
  end

  assign parallel_out = pout_q;
  assign out_valid    = ovalid_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;
`ifdef PARITY_CHECK_EN
  assign parity_err   = perr_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: directed vector table, parity sequences, and random traffic against a word-level model.
module tb_sipo_frame_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, serial_in, serial_valid, frame_abort, out_ready, overrun_clr;
  logic [W-1:0] parallel_out;
  logic         out_valid, busy, overrun, parity_err;

  int checks = 0;
  int errors = 0;

  sipo_frame_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .frame_abort(frame_abort), .out_ready(out_ready), .overrun_clr(overrun_clr),
    .parallel_out(parallel_out), .out_valid(out_valid), .busy(busy),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Reference model state: bits gathered so far, value, pending parity bit, output side.
  int           m_n;
  int unsigned  m_v;
  bit           m_par_pend;
  int unsigned  m_pout;
  bit           m_valid, m_ovr, m_perr;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_v = 0; m_par_pend = 0; m_pout = 0; m_valid = 0; m_ovr = 0; m_perr = 0;
  endtask

  // Applies the frame rules to the inputs held across the edge just taken.
  task automatic model_edge();
    bit complete;
    int unsigned word;
    bit ovr_set;
    complete = 0; word = 0; ovr_set = 0;
    if (rst) begin
      model_reset();
      return;
    end
    m_perr = 0;
    if (frame_abort) begin
      m_n = 0; m_v = 0; m_par_pend = 0;
    end else if (serial_valid) begin
      if (m_par_pend) begin
        m_par_pend = 0;
        if ((($countones(m_v) + int'(serial_in)) % 2) == 0) begin
          complete = 1; word = m_v;
        end else begin
          m_perr = 1;
        end
      end else begin
        m_v = (m_v * 2 + int'(serial_in)) % (1 << W);
        m_n++;
        if (m_n == W) begin
          m_n = 0;
`ifdef PARITY_CHECK_EN
          m_par_pend = 1;
`else
          complete = 1; word = m_v;
`endif
        end
      end
    end
    if (complete) begin
      if (!m_valid || out_ready) begin
        m_pout = word; m_valid = 1;
      end else begin
        ovr_set = 1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    if (ovr_set) m_ovr = 1;
    else if (overrun_clr) m_ovr = 0;
  endtask

  task automatic drive(input bit r, input bit sv, input bit si, input bit ab, input bit rd, input bit cl);
    rst = r; serial_valid = sv; serial_in = si; frame_abort = ab; out_ready = rd; overrun_clr = cl;
  endtask

  typedef struct {
    bit r, sv, si, ab, rd, cl;
    logic [W-1:0] e_pout;
    bit e_valid, e_busy, e_ovr;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit r, sv, si, ab, rd, cl, input logic [W-1:0] p, input bit v, b, o);
    vec_t x;
    x.r = r; x.sv = sv; x.si = si; x.ab = ab; x.rd = rd; x.cl = cl;
    x.e_pout = p; x.e_valid = v; x.e_busy = b; x.e_ovr = o;
    vt.push_back(x);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    model_reset();

`ifndef PARITY_CHECK_EN
    //   r sv si ab rd cl   pout     v b o
    add(1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 4'b0000, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 4'b0000, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 4'b0000, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 4'b1011, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 4'b1011, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 4'b1011, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 4'b1011, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 4'b1011, 0, 1, 0);
    add(0, 1, 1, 1, 0, 0, 4'b1011, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 4'b1011, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 4'b1011, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 4'b1011, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 4'b0110, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 4'b0110, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0, 4'b0110, 1, 1, 0);
    add(0, 1, 1, 0, 0, 0, 4'b0110, 1, 1, 0);
    add(0, 1, 1, 0, 0, 0, 4'b0110, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 4'b0110, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 4'b0110, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0, 4'b0110, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0, 4'b0110, 1, 1, 0);
    add(0, 1, 1, 0, 1, 0, 4'b1001, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 4'b1001, 1, 1, 0);
    add(0, 1, 1, 0, 0, 0, 4'b1001, 1, 1, 0);
    add(0, 1, 1, 0, 0, 0, 4'b1001, 1, 1, 0);
    add(0, 1, 1, 0, 0, 1, 4'b1001, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0, 4'b1001, 1, 1, 1);
    add(1, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].r, vt[i].sv, vt[i].si, vt[i].ab, vt[i].rd, vt[i].cl);
      @(posedge clk); #1;
      check($sformatf("vec%0d.pout", i), parallel_out, vt[i].e_pout);
      check($sformatf("vec%0d.valid", i), out_valid, vt[i].e_valid);
      check($sformatf("vec%0d.busy", i), busy, vt[i].e_busy);
      check($sformatf("vec%0d.ovr", i), overrun, vt[i].e_ovr);
      check($sformatf("vec%0d.perr", i), parity_err, 0);
      $display("vec %0d: pout=%b valid=%0b busy=%0b ovr=%0b", i, parallel_out, out_valid, busy, overrun);
    end
`else
    // Parity build: good word, bad parity, then reset mid-frame.
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    begin
      bit bits_a[5] = '{1, 0, 1, 1, 1};
      for (int i = 0; i < 5; i++) begin
        drive(0, 1, bits_a[i], 0, 0, 0);
        @(posedge clk); #1;
        check($sformatf("par_ok.busy%0d", i), busy, (i < 4) ? 1 : 0);
      end
      check("par_ok.pout", parallel_out, 4'b1011);
      check("par_ok.valid", out_valid, 1);
      check("par_ok.perr", parity_err, 0);
      bits_a = '{1, 0, 1, 1, 0};
      for (int i = 0; i < 5; i++) begin
        drive(0, 1, bits_a[i], 0, 1, 0);
        @(posedge clk); #1;
      end
      check("par_bad.perr", parity_err, 1);
      check("par_bad.valid", out_valid, 0);
      check("par_bad.ovr", overrun, 0);
      drive(0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      check("par_bad.perr_pulse", parity_err, 0);
      drive(0, 1, 1, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 check("par_rst.busy_pre", busy, 1);
      drive(1, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      check("par_rst.busy", busy, 0);
      $display("parity seq: pout=%b valid=%0b", parallel_out, out_valid);
    end
`endif

    // Random traffic against the model.
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); model_edge(); #1;
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 60), $urandom_range(0, 1),
            ($urandom_range(0, 99) < 3), $urandom_range(0, 1), ($urandom_range(0, 99) < 5));
      @(posedge clk);
      model_edge();
      #1;
      check("rnd.pout", parallel_out, m_pout);
      check("rnd.valid", out_valid, m_valid);
      check("rnd.busy", busy, (m_n != 0) || m_par_pend);
      check("rnd.ovr", overrun, m_ovr);
      check("rnd.perr", parity_err, m_perr);
      if (c % 250 == 0)
        $display("rnd %0d: pout=%b valid=%0b busy=%0b ovr=%0b", c, parallel_out, out_valid, busy, overrun);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
